// File: rtl/tpg_multimode.sv
// Multi-mode video test pattern generator: programmable raster timing plus fade, colour bars,
// checkerboard, grey ramp and solid patterns, with all outputs registered and mutually aligned.
module tpg_multimode #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CNT_W     = 12,
    parameter int unsigned FADE_STEP = 9,
    parameter int unsigned CHK_LOG2  = 5
) (
    input  logic              I_pxl_clk,
    input  logic              I_rst_n,
    input  logic [CNT_W-1:0]  I_h_total,
    input  logic [CNT_W-1:0]  I_h_sync,
    input  logic [CNT_W-1:0]  I_h_bporch,
    input  logic [CNT_W-1:0]  I_h_res,
    input  logic [CNT_W-1:0]  I_v_total,
    input  logic [CNT_W-1:0]  I_v_sync,
    input  logic [CNT_W-1:0]  I_v_bporch,
    input  logic [CNT_W-1:0]  I_v_res,
    input  logic              I_hs_pol,
    input  logic              I_vs_pol,
    input  logic [2:0]        I_mode,
    output logic              O_de,
    output logic              O_hs,
    output logic              O_vs,
    output logic              O_sof,
    output logic [DATA_W-1:0] O_data_r,
    output logic [DATA_W-1:0] O_data_g,
    output logic [DATA_W-1:0] O_data_b
);

    typedef enum logic [0:0] {
        StUp   = 1'b0,
        StDown = 1'b1
    } fade_st_e;

    localparam logic [DATA_W-1:0] MaxC  = '1;
    localparam logic [DATA_W-1:0] StepC = DATA_W'(FADE_STEP);
    localparam logic [CNT_W-1:0]  OneC  = CNT_W'(1);

    logic [CNT_W-1:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [CNT_W-1:0]  x_q, x_d, y_q, y_d;
    logic              line_act_q, line_act_d;
    logic [CNT_W-1:0]  bar_cnt_q, bar_cnt_d;
    logic [2:0]        bar_idx_q, bar_idx_d;
    logic [2:0]        mode_q, mode_d, mode_eff;
    logic [DATA_W-1:0] fade_q, fade_d;
    fade_st_e          fade_st_q, fade_st_d;

    logic              de_q, hs_act_q, vs_act_q, sof_q;
    logic [DATA_W-1:0] r_q, g_q, b_q, r_d, g_d, b_d;

    logic              h_wrap, v_wrap, hs_raw, vs_raw, de_raw, sof_raw;
    logic [CNT_W+1:0]  h_de_start, h_de_end, v_de_start, v_de_end;
    logic [CNT_W-1:0]  bar_w;
    logic [2:0]        bar_cur;

    // Raster counters and raw timing decode
    assign h_wrap  = (h_cnt_q >= I_h_total - OneC);
    assign v_wrap  = (v_cnt_q >= I_v_total - OneC);
    assign hs_raw  = (h_cnt_q < I_h_sync);
    assign vs_raw  = (v_cnt_q < I_v_sync);
    assign sof_raw = (h_cnt_q == '0) && (v_cnt_q == '0);

    // Extra headroom so sync+porch+res sums never overflow the comparison
    assign h_de_start = (CNT_W+2)'(I_h_sync) + (CNT_W+2)'(I_h_bporch);
    assign h_de_end   = h_de_start + (CNT_W+2)'(I_h_res);
    assign v_de_start = (CNT_W+2)'(I_v_sync) + (CNT_W+2)'(I_v_bporch);
    assign v_de_end   = v_de_start + (CNT_W+2)'(I_v_res);

    assign de_raw = ((CNT_W+2)'(h_cnt_q) >= h_de_start) && ((CNT_W+2)'(h_cnt_q) < h_de_end) &&
                    ((CNT_W+2)'(v_cnt_q) >= v_de_start) && ((CNT_W+2)'(v_cnt_q) < v_de_end);

    always_comb begin
        h_cnt_d = h_wrap ? '0 : h_cnt_q + OneC;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + OneC;
        end
    end

    // Active-area coordinates
    always_comb begin
        x_d        = de_raw ? x_q + OneC : '0;
        y_d        = y_q;
        line_act_d = h_wrap ? 1'b0 : (line_act_q | de_raw);
        if (h_wrap) begin
            if (v_wrap) begin
                y_d = '0;
            end else if (line_act_q || de_raw) begin
                y_d = y_q + OneC;
            end
        end
    end

    // Colour bar tracking: W pixels per bar, index saturating at the last bar
    assign bar_w   = I_h_res >> 3;
    assign bar_cur = (bar_w == '0) ? 3'd7 : bar_idx_q;

    always_comb begin
        bar_cnt_d = '0;
        bar_idx_d = '0;
        if (de_raw) begin
            if (bar_cnt_q >= bar_w - OneC) begin
                bar_cnt_d = '0;
                bar_idx_d = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
            end else begin
                bar_cnt_d = bar_cnt_q + OneC;
                bar_idx_d = bar_idx_q;
            end
        end
    end

    // Mode is latched at frame start; the frame-start pixel already sees the new value
    assign mode_d   = sof_raw ? I_mode : mode_q;
    assign mode_eff = mode_d;

    // Fade FSM: state register
    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            fade_st_q <= StUp;
            fade_q    <= '0;
        end else begin
            fade_st_q <= fade_st_d;
            fade_q    <= fade_d;
        end
    end

    // Fade FSM: next state
    always_comb begin
        fade_st_d = fade_st_q;
        if (sof_raw) begin
            unique case (fade_st_q)
                StUp:    if (fade_q > MaxC - StepC) fade_st_d = StDown;
                StDown:  if (fade_q < StepC) fade_st_d = StUp;
                default: fade_st_d = StUp;
            endcase
        end
    end

    // Fade FSM: output (fade level), clamped at both ends
    always_comb begin
        fade_d = fade_q;
        if (sof_raw) begin
            unique case (fade_st_q)
                StUp:    fade_d = (fade_q > MaxC - StepC) ? MaxC : fade_q + StepC;
                StDown:  fade_d = (fade_q < StepC) ? '0 : fade_q - StepC;
                default: fade_d = '0;
            endcase
        end
    end

    // Pixel colour
    always_comb begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (de_raw) begin
            case (mode_eff)
                3'd0: begin
                    r_d = fade_q;
                    g_d = MaxC - fade_q;
                end
                3'd1: begin
                    r_d = {DATA_W{~bar_cur[1]}};
                    g_d = {DATA_W{~bar_cur[2]}};
                    b_d = {DATA_W{~bar_cur[0]}};
                end
                3'd2: begin
                    r_d = {DATA_W{x_q[CHK_LOG2] ^ y_q[CHK_LOG2]}};
                    g_d = r_d;
                    b_d = r_d;
                end
                3'd3: begin
                    r_d = x_q[DATA_W-1:0];
                    g_d = x_q[DATA_W-1:0];
                    b_d = x_q[DATA_W-1:0];
                end
                3'd4: begin
                    r_d = MaxC;
                    g_d = MaxC;
                    b_d = MaxC;
                end
                default: begin
                    r_d = '0;
                    g_d = '0;
                    b_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            line_act_q <= 1'b0;
            bar_cnt_q  <= '0;
            bar_idx_q  <= '0;
            mode_q     <= '0;
            de_q       <= 1'b0;
            hs_act_q   <= 1'b0;
            vs_act_q   <= 1'b0;
            sof_q      <= 1'b0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            line_act_q <= line_act_d;
            bar_cnt_q  <= bar_cnt_d;
            bar_idx_q  <= bar_idx_d;
            mode_q     <= mode_d;
            de_q       <= de_raw;
            hs_act_q   <= hs_raw;
            vs_act_q   <= vs_raw;
            sof_q      <= sof_raw;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
        end
    end

    // Syncs are held as "active" flags so reset yields the inactive level for either polarity
    assign O_hs     = hs_act_q ? I_hs_pol : ~I_hs_pol;
    assign O_vs     = vs_act_q ? I_vs_pol : ~I_vs_pol;
    assign O_de     = de_q;
    assign O_sof    = sof_q;
    assign O_data_r = r_q;
    assign O_data_g = g_q;
    assign O_data_b = b_q;

endmodule

// File: tb/tb_tpg_multimode.sv
// Directed bench for tpg_multimode: table-driven pattern vectors plus hand-written
// timing, fade, mode-switch, polarity and mid-line reset sequences.
module tb_tpg_multimode;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] h_total = 12'd16, h_sync = 12'd2, h_bporch = 12'd2, h_res = 12'd8;
    logic [11:0] v_total = 12'd10, v_sync = 12'd1, v_bporch = 12'd1, v_res = 12'd6;
    logic        hs_pol = 1'b0, vs_pol = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic        o_de, o_hs, o_vs, o_sof;
    logic [7:0]  o_r, o_g, o_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  mode;
        logic [11:0] hres;
        int          x;
        int          y;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
    } vec_t;

    vec_t vt [23];
    int   fexp [13] = '{51, 102, 153, 204, 255, 255, 204, 153, 102, 51, 0, 0, 51};

    tpg_multimode #(
        .DATA_W   (8),
        .CNT_W    (12),
        .FADE_STEP(51),
        .CHK_LOG2 (1)
    ) dut (
        .I_pxl_clk (clk),
        .I_rst_n   (rst_n),
        .I_h_total (h_total),
        .I_h_sync  (h_sync),
        .I_h_bporch(h_bporch),
        .I_h_res   (h_res),
        .I_v_total (v_total),
        .I_v_sync  (v_sync),
        .I_v_bporch(v_bporch),
        .I_v_res   (v_res),
        .I_hs_pol  (hs_pol),
        .I_vs_pol  (vs_pol),
        .I_mode    (mode),
        .O_de      (o_de),
        .O_hs      (o_hs),
        .O_vs      (o_vs),
        .O_sof     (o_sof),
        .O_data_r  (o_r),
        .O_data_g  (o_g),
        .O_data_b  (o_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] pix();
        return {7'd0, o_de, o_r, o_g, o_b};
    endfunction

    function automatic logic [31:0] ex(input logic de, input logic [7:0] r, input logic [7:0] g,
                                       input logic [7:0] b);
        return {7'd0, de, r, g, b};
    endfunction

    task automatic setv(input int i, input logic [2:0] m, input logic [11:0] hr, input int x,
                        input int y, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b);
        vt[i] = '{m, hr, x, y, r, g, b};
    endtask

    initial begin
        int hs_n, vs_n, de_n, sof_n, bad, first_de, first_sof, last_sof;

        // Pixel (x,y) of frame 0 is visible after 37 + 16*y + x edges past reset release
        setv(0,  3'd0, 12'd8, 0, 0, 8'd51,  8'd204, 8'd0);
        setv(1,  3'd0, 12'd8, 3, 5, 8'd51,  8'd204, 8'd0);
        setv(2,  3'd1, 12'd8, 0, 0, 8'hFF, 8'hFF, 8'hFF);
        setv(3,  3'd1, 12'd8, 1, 0, 8'hFF, 8'hFF, 8'h00);
        setv(4,  3'd1, 12'd8, 2, 0, 8'h00, 8'hFF, 8'hFF);
        setv(5,  3'd1, 12'd8, 3, 1, 8'h00, 8'hFF, 8'h00);
        setv(6,  3'd1, 12'd8, 4, 2, 8'hFF, 8'h00, 8'hFF);
        setv(7,  3'd1, 12'd8, 5, 3, 8'hFF, 8'h00, 8'h00);
        setv(8,  3'd1, 12'd8, 6, 4, 8'h00, 8'h00, 8'hFF);
        setv(9,  3'd1, 12'd8, 7, 5, 8'h00, 8'h00, 8'h00);
        setv(10, 3'd1, 12'd4, 0, 0, 8'h00, 8'h00, 8'h00);
        setv(11, 3'd1, 12'd4, 3, 2, 8'h00, 8'h00, 8'h00);
        setv(12, 3'd2, 12'd8, 0, 0, 8'h00, 8'h00, 8'h00);
        setv(13, 3'd2, 12'd8, 2, 0, 8'hFF, 8'hFF, 8'hFF);
        setv(14, 3'd2, 12'd8, 2, 2, 8'h00, 8'h00, 8'h00);
        setv(15, 3'd2, 12'd8, 1, 3, 8'hFF, 8'hFF, 8'hFF);
        setv(16, 3'd3, 12'd8, 5, 1, 8'd5,  8'd5,  8'd5);
        setv(17, 3'd3, 12'd8, 7, 0, 8'd7,  8'd7,  8'd7);
        setv(18, 3'd4, 12'd8, 0, 0, 8'hFF, 8'hFF, 8'hFF);
        setv(19, 3'd4, 12'd8, 7, 5, 8'hFF, 8'hFF, 8'hFF);
        setv(20, 3'd5, 12'd8, 2, 1, 8'h00, 8'h00, 8'h00);
        setv(21, 3'd6, 12'd8, 4, 2, 8'h00, 8'h00, 8'h00);
        setv(22, 3'd7, 12'd8, 6, 3, 8'h00, 8'h00, 8'h00);

        // Reset state with active-high polarity selected
        hs_pol = 1'b1;
        vs_pol = 1'b1;
        mode   = 3'd6;
        step(2);
        chk("reset_state", 32'({o_de, o_sof, o_hs, o_vs, o_r, o_g, o_b}), 32'h0);

        // Polarity 1,1 with invalid mode 6: active-high syncs, data always 0
        @(negedge clk);
        rst_n = 1'b1;
        hs_n = 0; vs_n = 0; de_n = 0; bad = 0;
        for (int i = 0; i < 160; i++) begin
            step(1);
            if (o_hs) hs_n++;
            if (o_vs) vs_n++;
            if (o_de) de_n++;
            if ((o_r | o_g | o_b) != 8'h00) bad++;
        end
        chk("pol_hs_high", 32'(hs_n), 32'd20);
        chk("pol_vs_high", 32'(vs_n), 32'd16);
        chk("pol_de_count", 32'(de_n), 32'd48);
        chk("pol_data_zero", 32'(bad), 32'd0);

        // Table-driven pattern vectors
        hs_pol = 1'b0;
        vs_pol = 1'b0;
        for (int i = 0; i < 23; i++) begin
            mode  = vt[i].mode;
            h_res = vt[i].hres;
            do_reset();
            step(37 + 16 * vt[i].y + vt[i].x);
            chk($sformatf("vec%0d_m%0d_x%0d_y%0d", i, vt[i].mode, vt[i].x, vt[i].y), pix(),
                ex(1'b1, vt[i].r, vt[i].g, vt[i].b));
        end

        // Raster timing over two frames
        mode  = 3'd0;
        h_res = 12'd8;
        do_reset();
        hs_n = 0; vs_n = 0; de_n = 0; sof_n = 0; bad = 0;
        first_de = -1; first_sof = -1; last_sof = -1;
        for (int i = 0; i < 320; i++) begin
            step(1);
            if (!o_hs) hs_n++;
            if (!o_vs) vs_n++;
            if (o_de) begin
                de_n++;
                if (first_de < 0) first_de = i;
            end
            if (o_sof) begin
                sof_n++;
                if (first_sof < 0) first_sof = i;
                last_sof = i;
            end
            if (!o_de && (o_r | o_g | o_b) != 8'h00) bad++;
        end
        chk("tim_hs_low", 32'(hs_n), 32'd40);
        chk("tim_vs_low", 32'(vs_n), 32'd32);
        chk("tim_de_count", 32'(de_n), 32'd96);
        chk("tim_sof_count", 32'(sof_n), 32'd2);
        chk("tim_first_sof", 32'(first_sof), 32'd0);
        chk("tim_last_sof", 32'(last_sof), 32'd160);
        chk("tim_first_de", 32'(first_de), 32'd36);
        chk("tim_blank_zero", 32'(bad), 32'd0);

        // Fade sequence, first active pixel of successive frames
        mode = 3'd0;
        do_reset();
        step(37);
        for (int f = 0; f < 13; f++) begin
            chk($sformatf("fade_frame%0d", f), pix(),
                ex(1'b1, 8'(fexp[f]), 8'(255 - fexp[f]), 8'h00));
            step(160);
        end

        // Mode switch 2 -> 1 mid-frame takes effect only from the next frame
        mode = 3'd2;
        do_reset();
        step(37);
        chk("sw_chk_x0", pix(), ex(1'b1, 8'h00, 8'h00, 8'h00));
        mode = 3'd1;
        step(2);
        chk("sw_chk_x2", pix(), ex(1'b1, 8'hFF, 8'hFF, 8'hFF));
        step(159);
        chk("sw_bar_x1", pix(), ex(1'b1, 8'hFF, 8'hFF, 8'h00));

        // Reset mid-line and during sync, then restart from H=0
        mode = 3'd4;
        do_reset();
        step(37);
        chk("rst_pre_px", pix(), ex(1'b1, 8'hFF, 8'hFF, 8'hFF));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_px", pix(), 32'h0);
        chk("rst_mid_sync", 32'({o_hs, o_vs, o_sof}), 32'h6);
        @(negedge clk);
        rst_n = 1'b1;
        step(2);
        chk("rst_sync_act", 32'({o_hs, o_vs}), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_sync_inact", 32'({o_hs, o_vs, o_sof, o_de}), 32'hC);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        chk("rst_restart_sof", 32'(o_sof), 32'h1);
        step(36);
        chk("rst_restart_px", pix(), ex(1'b1, 8'hFF, 8'hFF, 8'hFF));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
